// File: rtl/led_fade_driver.sv
// PWM output stage for the 4-LED bounce sequencer: lit LEDs drive at full
// brightness, released LEDs fade out in fixed steps on a shared prescaler tick.
module led_fade_driver #(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned FADE_DIV  = 50000,
    parameter int unsigned FADE_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] leds_in,
    output logic [3:0] leds_out,
    output logic       busy
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned PRE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_BITS-1:0] LVL_FULL  = '1;
    localparam logic [PWM_BITS-1:0] LVL_STEP  = PWM_BITS'(FADE_STEP);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(FADE_DIV - 1);

    logic [3:0]                       leds_in_r;
    logic [PRE_W-1:0]                 pre_cnt;
    logic [PWM_BITS-1:0]              pwm_cnt;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  level;

    logic                             tick_c;
    logic [PRE_W-1:0]                 pre_nxt_c;
    logic [PWM_BITS-1:0]              pwm_nxt_c;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  level_nxt_c;
    logic [3:0]                       out_nxt_c;
    logic                             busy_c;

    // Shared fade prescaler and free-running PWM counter, both held at 0 while disabled.
    always_comb begin
        tick_c    = 1'b0;
        pre_nxt_c = '0;
        pwm_nxt_c = '0;
        if (en) begin
            tick_c    = (pre_cnt == PRE_LAST);
            pre_nxt_c = tick_c ? '0 : pre_cnt + PRE_W'(1);
            pwm_nxt_c = pwm_cnt + PWM_BITS'(1);
        end
    end

    // Per-channel level update (load-to-full beats a fade tick) and pin compare.
    always_comb begin
        level_nxt_c = level;
        out_nxt_c   = '0;
        busy_c      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy_c = busy_c | (level[i] != '0);
            if (!en) begin
                level_nxt_c[i] = '0;
            end else if (leds_in_r[i]) begin
                level_nxt_c[i] = LVL_FULL;
            end else if (tick_c) begin
                level_nxt_c[i] = (level[i] < LVL_STEP) ? '0 : level[i] - LVL_STEP;
            end
            if (en) begin
                out_nxt_c[i] = (level[i] == LVL_FULL) || (pwm_cnt < level[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_in_r <= '0;
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            level     <= '0;
            leds_out  <= '0;
        end else begin
            leds_in_r <= leds_in;
            pre_cnt   <= pre_nxt_c;
            pwm_cnt   <= pwm_nxt_c;
            level     <= level_nxt_c;
            leds_out  <= out_nxt_c;
        end
    end

    assign busy = busy_c;

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the 4-LED bounce sequencer and the board LED pins. It takes the sequencer's on/off LED vector and drives each pin with a PWM signal. A lit LED drives at full brightness, and a released LED fades out in fixed steps, which gives the bouncing light a trailing afterglow. Each LED channel is independent, and all channels share one PWM counter and one fade prescaler.

## Interface
Parameters:
- PWM_BITS, 8: brightness/PWM counter width; full level = 2^PWM_BITS-1.
- FADE_DIV, 50000: clk cycles per fade step; legal range ≥2.
- FADE_STEP, 8: level decrement per fade step; legal range 1..2^PWM_BITS-1.

Ports:
- clk, input, 1: system clock. Clocking and reset: one clock; reset is asynchronous and active-low.
- rst_n, input, 1: async active-low reset.
- en, input, 1: driver enable; low forces dark/idle.
- leds_in, input, 4: sequencer LED vector, synchronous to clk.
- leds_out, output, 4: PWM-driven LED pins, registered.
- busy, output, 1: high while any channel level is nonzero.

## Operation
- **Input register:** leds_in is captured into leds_in_r on every edge.
- **Channel levels:** channel i holds level[i], which is PWM_BITS wide.
  - If leds_in_r[i]=1, then level[i] loads full.
  - Else, on a fade tick, level[i] loads level[i]-FADE_STEP, saturating at 0 (no wrap-around below 0).
  - Else, level[i] holds.
  - If leds_in_r[i]=1 and a tick occur in the same cycle, the load to full wins.
- **Fade prescaler:** counts 0..FADE_DIV-1. tick=1 for the single cycle where count = FADE_DIV-1, then count wraps to 0. It is ceil(log2(FADE_DIV)) bits wide and runs continuously while en=1.
- **PWM counter:** free-running, PWM_BITS wide, wraps from all-ones to 0.
- **Pin output:** leds_out[i] is registered.
  - leds_out[i] = 1 if level[i] = full (constant on, no 1-cycle dropout).
  - Otherwise leds_out[i] = (pwm_cnt < level[i]).
  - Level 0 means constant off.
- **busy:** OR over (level[i] ≠ 0), combinational from the level registers.
- **en = 0 (synchronous):**
  - Prescaler, PWM counter, all levels and leds_out clear on the next edge.
  - leds_in_r keeps sampling.
  - While en=0, levels do not load.
- **en 0→1:** counters start from 0 and levels start from 0. The first load happens on the first edge with en=1 and leds_in_r=1.
- **Reset:** rst_n low asynchronously clears leds_in_r, all levels, both counters and leds_out. busy=0 follows.
  - Reset mid-fade discards the fade entirely.
  - Operation restarts on the first edge after rst_n rises.

## Timing
- **Reset values:** leds_out=4'b0000, busy=0.
- **Turn-on latency:**
  - leds_in[i] rises before edge N.
  - leds_in_r[i]=1 after N.
  - level[i]=full after N+1, and busy=1 from then.
  - leds_out[i]=1 after N+2.
- **Release:**
  - leds_in[i] falls before edge N, so leds_in_r[i]=0 after N.
  - The first decrement happens on the first tick edge after N.
  - Decrements then repeat every FADE_DIV cycles.
  - leds_out follows each level change one edge later.
- **Fade duration:** from full, the fade takes ceil(full/FADE_STEP) ticks.
- **busy fall:** busy falls in the same cycle the last nonzero level reaches 0.
- **Duty:** over any PWM period with a stable level L, there are L high cycles, except L=full, which gives 2^PWM_BITS high cycles.

## Test plan
All scenarios use PWM_BITS=4, FADE_DIV=16, FADE_STEP=4, so full=15.

1. **Reset mid-activity:** drive leds_in=4'b1111, then pull rst_n low between edges → leds_out=0 and busy=0 immediately without waiting for a clock. After release, each output is 0 until 2 edges after re-sampling.
2. **Hold:** hold leds_in=4'b0001 → leds_out[0] rises at N+2 and stays high every cycle; leds_out[3:1]=0; busy=1.
3. **Fade:** release leds_in[0] → level steps 15→11→7→3→0 on successive ticks, 16 cycles apart. Measured high count per 16-cycle window is 11, 7, 3, 0. busy falls when the level hits 0, and no wrap to 15 occurs.
4. **Retrigger and collision:** re-assert leds_in[0] while level=7, and align leds_in_r=1 with a tick → level=15 next edge (not 3); leds_out[0] is constant high.
5. **Enable:** drop en while two channels are fading → leds_out=0 and busy=0 after one edge, and leds_in changes are ignored. Raise en with leds_in=4'b0100 → only channel 2 lights, 2 edges later.
6. **Walk:** drive leds_in through 0001→0010→0100→1000, 20 cycles each → current LED is constant high and previous LEDs show decaying duty. Each channel individually obeys scenario 3 and has no crosstalk.
